// File: rtl/pe_pkg.sv
// Shared types and width helper for the sequential priority-encoder family.
package pe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } pe_state_e;

    // Bits needed to hold values 0..value-1.
    function automatic int pe_clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pe_find_first.sv
// Combinational find-first-set over an N-bit vector.
// Direction: MSB-first by default, LSB-first when PE_LSB_FIRST_EN is defined.
module pe_find_first
    import pe_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = pe_clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          found
);

    // The last matching iteration wins, so the scan runs toward the priority end.
    always_comb begin
        idx   = '0;
        found = 1'b0;
`ifdef PE_LSB_FIRST_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/pe_multi_seq.sv
// Sequential multi-index priority encoder: captures a request vector and emits up to
// MAX_OUT set-bit indices, one per accepted beat. Direction macro: PE_LSB_FIRST_EN.
module pe_multi_seq
    import pe_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int MAX_OUT = 3,
    localparam int IW      = pe_clog2(N),
    localparam int CW      = pe_clog2(MAX_OUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_vec,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic [CW-1:0] out_rank,
    output logic          out_last,
    output logic          done,
    output logic [CW-1:0] done_cnt,
    output pe_state_e     dbg_state
);

    // Handshakes: a transfer happens on an edge where valid & ready & enable are all high;
    // valid never depends on ready, and a presented beat holds until it is accepted.
    pe_state_e       r_state;
    pe_state_e       w_next_state;
    logic [N-1:0]    r_rem;
    logic            r_out_valid;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_rank;
    logic            r_last;
    logic            r_done;
    logic [CW-1:0]   r_done_cnt;

    logic            w_capture;
    logic            w_accept;
    logic            w_advance;
    logic            w_finish;
    logic [N-1:0]    w_src;
    logic [IW-1:0]   w_next_idx;
    logic            w_found;
    logic [CW-1:0]   w_next_rank;
    logic            w_next_last;

    assign w_capture = (r_state == IDLE) && enable && in_valid;
    assign w_accept  = (r_state == EMIT) && r_out_valid && enable && out_ready;
    assign w_advance = w_accept && !r_last;
    assign w_finish  = w_accept && r_last;

    // Source for the next beat: the fresh vector in IDLE, else rem minus the current bit.
    assign w_src = (r_state == IDLE) ? in_vec : (r_rem & ~(N'(1) << r_idx));

    pe_find_first #(.N(N), .IW(IW)) u_find_first (
        .vec   (w_src),
        .idx   (w_next_idx),
        .found (w_found)
    );

    assign w_next_rank = (r_state == IDLE) ? '0 : r_rank + CW'(1);
    assign w_next_last = (w_next_rank == CW'(MAX_OUT - 1)) ||
                         ((w_src & ~(N'(1) << w_next_idx)) == '0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_capture && w_found) w_next_state = EMIT;
            EMIT:    if (w_finish) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_rank      <= '0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_done_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_capture) begin
                r_rem <= w_src;
                if (w_found) begin
                    r_out_valid <= 1'b1;
                    r_idx       <= w_next_idx;
                    r_rank      <= w_next_rank;
                    r_last      <= w_next_last;
                end else begin
                    r_done     <= 1'b1;
                    r_done_cnt <= '0;
                end
            end else if (w_advance) begin
                r_rem  <= w_src;
                r_idx  <= w_next_idx;
                r_rank <= w_next_rank;
                r_last <= w_next_last;
            end else if (w_finish) begin
                // Any bits still set past MAX_OUT beats are dropped here.
                r_rem       <= '0;
                r_out_valid <= 1'b0;
                r_last      <= 1'b0;
                r_done      <= 1'b1;
                r_done_cnt  <= r_rank + CW'(1);
            end
        end
    end

    assign in_ready  = (r_state == IDLE) && enable;
    assign out_valid = r_out_valid && enable;
    assign out_idx   = r_idx;
    assign out_rank  = r_rank;
    assign out_last  = r_last;
    assign done      = r_done;
    assign done_cnt  = r_done_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_pe_multi_seq.sv
// Directed, table-driven bench for pe_multi_seq (N=8, MAX_OUT=3).
module tb_pe_multi_seq;
    import pe_pkg::*;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic [1:0] out_rank;
    logic       out_last;
    logic       done;
    logic [1:0] done_cnt;
    pe_state_e  dbg_state;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [7:0] vec;
        int         cnt;
        logic [2:0] i0;
        logic [2:0] i1;
        logic [2:0] i2;
    } rec_t;

    rec_t tbl[7];

    pe_multi_seq #(.N(8), .MAX_OUT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_rank  (out_rank),
        .out_last  (out_last),
        .done      (done),
        .done_cnt  (done_cnt),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [2:0] idx, input int rank, input logic last);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_idx"},   32'(out_idx),   32'(idx));
        chk({tag, "_rank"},  32'(out_rank),  32'(rank));
        chk({tag, "_last"},  32'(out_last),  32'(last));
        chk({tag, "_done"},  32'(done),      32'd0);
    endtask

    task automatic chk_done(input string tag, input int cnt);
        chk({tag, "_done"},     32'(done),      32'd1);
        chk({tag, "_done_cnt"}, 32'(done_cnt),  32'(cnt));
        chk({tag, "_valid_lo"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready),  32'd1);
    endtask

    // Present a vector for one edge, then follow its beats with out_ready held high.
    task automatic run_vector(input rec_t r, input int n);
        logic [2:0] e;
        string tag;
        tag = $sformatf("vec%0d", n);
        chk({tag, "_ready_pre"}, 32'(in_ready), 32'd1);
        in_vec    = r.vec;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_vec   = '0;
        if (r.cnt == 0) begin
            chk_done(tag, 0);
            tick();
            chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
            chk({tag, "_no_valid"}, 32'(out_valid), 32'd0);
        end else begin
            for (int b = 0; b < r.cnt; b++) begin
                e = (b == 0) ? r.i0 : ((b == 1) ? r.i1 : r.i2);
                chk_beat($sformatf("%s_b%0d", tag, b), e, b, b == r.cnt - 1);
                tick();
            end
            chk_done(tag, r.cnt);
        end
    endtask

    initial begin
        logic [2:0] bp_i0, bp_i1, en_i0, en_i1;
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;

`ifdef PE_LSB_FIRST_EN
        tbl[0] = '{8'h06, 2, 3'd1, 3'd2, 3'd0};
        tbl[1] = '{8'hC0, 2, 3'd6, 3'd7, 3'd0};
        tbl[2] = '{8'hFF, 3, 3'd0, 3'd1, 3'd2};
        tbl[3] = '{8'h00, 0, 3'd0, 3'd0, 3'd0};
        tbl[4] = '{8'h01, 1, 3'd0, 3'd0, 3'd0};
        tbl[5] = '{8'h81, 2, 3'd0, 3'd7, 3'd0};
        tbl[6] = '{8'h2A, 3, 3'd1, 3'd3, 3'd5};
        bp_i0 = 3'd2; bp_i1 = 3'd4;
        en_i0 = 3'd5; en_i1 = 3'd7;
`else
        tbl[0] = '{8'hC0, 2, 3'd7, 3'd6, 3'd0};
        tbl[1] = '{8'hFF, 3, 3'd7, 3'd6, 3'd5};
        tbl[2] = '{8'h00, 0, 3'd0, 3'd0, 3'd0};
        tbl[3] = '{8'h01, 1, 3'd0, 3'd0, 3'd0};
        tbl[4] = '{8'h81, 2, 3'd7, 3'd0, 3'd0};
        tbl[5] = '{8'h2A, 3, 3'd5, 3'd3, 3'd1};
        tbl[6] = '{8'h06, 2, 3'd2, 3'd1, 3'd0};
        bp_i0 = 3'd4; bp_i1 = 3'd2;
        en_i0 = 3'd7; en_i1 = 3'd5;
`endif

        // Reset state.
        tick();
        tick();
        chk("rst_state",    32'(dbg_state), 32'(IDLE));
        chk("rst_valid",    32'(out_valid), 32'd0);
        chk("rst_idx",      32'(out_idx),   32'd0);
        chk("rst_rank",     32'(out_rank),  32'd0);
        chk("rst_last",     32'(out_last),  32'd0);
        chk("rst_done",     32'(done),      32'd0);
        chk("rst_done_cnt", 32'(done_cnt),  32'd0);
        chk("rst_in_ready", 32'(in_ready),  32'd1);
        rst = 1'b0;
        tick();

        // Back-to-back vectors: each new one is presented in the done cycle of the last.
        for (int n = 0; n < 7; n++) begin
            run_vector(tbl[n], n);
        end
        tick();

        // Backpressure on beat 0 of 8'b0001_0100.
        out_ready = 1'b0;
        in_vec    = 8'b0001_0100;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_beat($sformatf("bp_hold%0d", c), bp_i0, 0, 1'b0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        chk_beat("bp_hold3", bp_i0, 0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk_beat("bp_b1", bp_i1, 1, 1'b1);
        tick();
        chk_done("bp", 2);
        tick();

        // Enable gap after beat 0 of 8'b1010_0000.
        in_vec   = 8'b1010_0000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_beat("en_b0", en_i0, 0, 1'b0);
        tick();
        enable = 1'b0;
        #1;
        chk("en_gap0_valid", 32'(out_valid), 32'd0);
        chk("en_gap0_ready", 32'(in_ready),  32'd0);
        tick();
        chk("en_gap1_valid", 32'(out_valid), 32'd0);
        chk("en_gap1_state", 32'(dbg_state), 32'(EMIT));
        tick();
        chk("en_gap2_valid", 32'(out_valid), 32'd0);
        chk("en_gap2_done",  32'(done),      32'd0);
        enable = 1'b1;
        #1;
        chk_beat("en_b1", en_i1, 1, 1'b1);
        tick();
        chk_done("en", 2);
        tick();

        // Reset mid-extraction of 8'hFF.
        in_vec   = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_state_emit", 32'(dbg_state), 32'(EMIT));
        chk("mid_rank1",      32'(out_rank),  32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_idx",   32'(out_idx),   32'd0);
        chk("mid_rst_rank",  32'(out_rank),  32'd0);
        chk("mid_rst_last",  32'(out_last),  32'd0);
        chk("mid_rst_done",  32'(done),      32'd0);
        tick();
        chk("mid_post_done",  32'(done),      32'd0);
        chk("mid_post_valid", 32'(out_valid), 32'd0);
        chk("mid_post_ready", 32'(in_ready),  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
